// File: rtl/vocab_match_ctrl_if.sv
// Bundle of the command, SRAM and result signals around the vocabulary
// match sequencer. The slave side is the sequencer itself; the master side
// is the environment (command logic plus the two SRAM read ports).
interface vocab_match_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2
);
    logic                  cs;
    logic                  start;
    logic [DATA_WIDTH-1:0] val_vocab;
    logic [DATA_WIDTH-1:0] val_input;
    logic [ADDR_WIDTH-1:0] addr_v;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [ID_WIDTH-1:0]   token_id;

    modport master (
        output cs, start, val_vocab, val_input,
        input  addr_v, addr_i, busy, done, found, token_id
    );

    modport slave (
        input  cs, start, val_vocab, val_input,
        output addr_v, addr_i, busy, done, found, token_id
    );
endinterface

// File: rtl/vocab_match_ctrl.sv
// Token-lookup sequencer: walks the vocabulary SRAM entry by entry, compares
// each entry byte-wise against the input-word SRAM, stops on the first full
// match or after the last entry, then reports found/token_id with a done pulse.
// Both SRAMs have one cycle of read latency, so every compared byte costs a
// FETCH cycle (address settles into the SRAM) and a CMP cycle (data compared).
module vocab_match_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WORD_LEN   = 4,
    parameter int NUM_WORDS  = 4,
    parameter int ID_WIDTH   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    vocab_match_ctrl_if.slave bus
);

    localparam int BYTE_W  = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam int WL_LOG2 = $clog2(WORD_LEN);

    localparam logic [BYTE_W-1:0]   LAST_BYTE  = BYTE_W'(WORD_LEN - 1);
    localparam logic [ID_WIDTH-1:0] LAST_ENTRY = ID_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [ID_WIDTH-1:0]   entry_r, entry_s;
    logic [BYTE_W-1:0]     byte_idx_r, byte_idx_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  found_r, found_s;
    logic [ID_WIDTH-1:0]   token_r, token_s;
    logic [ADDR_WIDTH-1:0] addr_v_r;
    logic [ADDR_WIDTH-1:0] addr_i_r;

    // Vocabulary address: entry*WORD_LEN + byte_idx, WORD_LEN being a power of two.
    function automatic logic [ADDR_WIDTH-1:0] vocab_addr(
        input logic [ID_WIDTH-1:0] entry,
        input logic [BYTE_W-1:0]   byte_idx
    );
        return (ADDR_WIDTH'(entry) << WL_LOG2) + ADDR_WIDTH'(byte_idx);
    endfunction

    // Next-state and next-output logic; cs low holds every register.
    always_comb begin
        state_s    = state_r;
        entry_s    = entry_r;
        byte_idx_s = byte_idx_r;
        busy_s     = busy_r;
        done_s     = done_r;
        found_s    = found_r;
        token_s    = token_r;
        if (bus.cs) begin
            case (state_r)
                IDLE: begin
                    done_s = 1'b0;
                    if (bus.start) begin
                        entry_s    = '0;
                        byte_idx_s = '0;
                        found_s    = 1'b0;
                        token_s    = '0;
                        busy_s     = 1'b1;
                        state_s    = FETCH;
                    end else begin
                        state_s = IDLE;
                    end
                end
                FETCH: begin
                    state_s = CMP;
                end
                CMP: begin
                    if (bus.val_vocab == bus.val_input) begin
                        if (byte_idx_r == LAST_BYTE) begin
                            found_s = 1'b1;
                            token_s = entry_r;
                            done_s  = 1'b1;
                            state_s = DONE;
                        end else begin
                            byte_idx_s = byte_idx_r + BYTE_W'(1);
                            state_s    = FETCH;
                        end
                    end else begin
                        if (entry_r == LAST_ENTRY) begin
                            found_s = 1'b0;
                            token_s = '0;
                            done_s  = 1'b1;
                            state_s = DONE;
                        end else begin
                            // Early skip: the rest of this entry cannot match.
                            entry_s    = entry_r + ID_WIDTH'(1);
                            byte_idx_s = '0;
                            state_s    = FETCH;
                        end
                    end
                end
                DONE: begin
                    done_s  = 1'b0;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
                default: begin
                    entry_s    = '0;
                    byte_idx_s = '0;
                    busy_s     = 1'b0;
                    done_s     = 1'b0;
                    state_s    = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counters, results and SRAM addresses, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            entry_r    <= '0;
            byte_idx_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            found_r    <= 1'b0;
            token_r    <= '0;
            addr_v_r   <= '0;
            addr_i_r   <= '0;
        end else begin
            state_r    <= state_s;
            entry_r    <= entry_s;
            byte_idx_r <= byte_idx_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            found_r    <= found_s;
            token_r    <= token_s;
            addr_v_r   <= vocab_addr(entry_s, byte_idx_s);
            addr_i_r   <= ADDR_WIDTH'(byte_idx_s);
        end
    end

    assign bus.addr_v   = addr_v_r;
    assign bus.addr_i   = addr_i_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.found    = found_r;
    assign bus.token_id = token_r;

endmodule

// File: doc/vocab_match_ctrl.md
Name: vocab_match_ctrl

Overview:
Sequencer for the token-lookup datapath: on a start request it walks the vocabulary SRAM entry by entry and compares each entry byte-wise against the input-word SRAM. It stops on the first full match or when the vocabulary is exhausted, then reports found/token_id. It owns the address ports of both read-only SRAMs and sits between the encoder's command logic and the two SRAM instances.

Parameters:
ADDR_WIDTH, 4, SRAM address width (both RAMs)
DATA_WIDTH, 8, SRAM data width, one character per word
WORD_LEN, 4, bytes per vocabulary entry and per input word; power of two; zero-padded
NUM_WORDS, 4, vocabulary entries; NUM_WORDS*WORD_LEN <= 2**ADDR_WIDTH
ID_WIDTH, max(1,$clog2(NUM_WORDS)), width of token_id

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cs  in  1  block enable; low = freeze all state
start  in  1  request a lookup; sampled only in IDLE with cs=1
val_vocab  in  DATA_WIDTH  vocab SRAM dout (registered, valid 1 cycle after addr)
val_input  in  DATA_WIDTH  input SRAM dout (registered, valid 1 cycle after addr)
addr_v  out  ADDR_WIDTH  vocab SRAM address = entry*WORD_LEN + byte_idx
addr_i  out  ADDR_WIDTH  input SRAM address = byte_idx
busy  out  1  high from start acceptance until done
done  out  1  single-cycle completion pulse
found  out  1  result: match found; held until next accepted start
token_id  out  ID_WIDTH  matching entry index; 0 when found=0; held until next start

Behaviour:
- Reset (async, rst_n=0): state IDLE; entry=0, byte_idx=0; addr_v=0, addr_i=0, busy=0, done=0, found=0, token_id=0. Reset mid-lookup aborts; no done pulse.
- All outputs registered; addresses driven from entry/byte_idx registers.
- States: IDLE, FETCH, CMP, DONE.
- IDLE: start=1 & cs=1 -> entry=0, byte_idx=0, found=0, token_id=0, busy=1, go FETCH. start outside IDLE ignored (no queueing).
- FETCH: addresses already presented; go CMP (SRAM read latency 1 cycle).
- CMP: compare val_vocab vs val_input (full DATA_WIDTH equality).
  - equal & byte_idx<WORD_LEN-1: byte_idx++, go FETCH.
  - equal & byte_idx==WORD_LEN-1: found=1, token_id=entry, go DONE.
  - unequal & entry<NUM_WORDS-1: entry++, byte_idx=0, go FETCH (early skip).
  - unequal & entry==NUM_WORDS-1: found=0, token_id=0, go DONE.
- DONE: done=1 for exactly this cycle, busy=0 at exit; go IDLE. A start in DONE is ignored; the earliest new start is accepted the cycle after the DONE state (i.e., in IDLE).
- Latency: 2 cycles per compared byte; done asserted 2*B+1 cycles after start-accept edge, B = total bytes compared. Full scan of a 4x4 vocab with no match and first-byte mismatches: B=4, done at cycle 9.
- cs=0: state, counters and outputs frozen (done pulse stretched if frozen in DONE). Addresses held, so SRAM dout remains stable and the comparison resumes correctly when cs returns to 1.
- First match wins; duplicate vocab entries report the lowest index.
- Address arithmetic: entry*WORD_LEN via shift; no wrap possible given parameter constraint.

Test Plan:
- Reset: rst_n=0 mid-FETCH of entry 2 -> all outputs 0 immediately, IDLE; start after release works normally.
- Hit on entry 2: vocab {"cat\0","dog\0","sun\0","map\0"}, input "sun\0" -> done pulse, found=1, token_id=2, B=1+1+4=6, done 13 cycles after start.
- Miss: input "zzz\0" -> found=0, token_id=0, B=4, done 9 cycles after start.
- Late mismatch: vocab entry0 "sum\0", input "sun\0" -> entry0 aborted at byte 2, addr_v sequence 0,1,2,4,..., hit reported as token_id=2.
- cs stall: drop cs for 3 cycles during a CMP state -> done delayed by exactly 3 cycles, result identical.
- Start while busy and in DONE ignored: pulse start mid-scan -> single done, result unchanged; start in IDLE next cycle -> new lookup clears found.
